// File: rtl/shift_reg_arbiter.sv
// ============================================================================
//  Module   : shift_reg_arbiter
//  Purpose  : Round-robin arbiter for two requesters. It loads the winner's
//             word and drives it MSB-first into a serial shift register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_reg_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sh_clr,
  output logic             sh_en,
  output logic             sh_d,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] q
);

  localparam int                  c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_ptr;
  logic               r_win;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_word;
  logic [WIDTH-2:0]   r_sreg;

  logic               w_win;
  logic [WIDTH-1:0]   w_word;

  // On a tie the requester that was not granted last wins.
  assign w_win  = (req0 && req1) ? ~r_ptr : req1;
  assign w_word = r_win ? data1 : data0;

  // Outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b1;
      r_win   <= 1'b0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_sreg  <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      sh_clr  <= 1'b0;
      sh_en   <= 1'b0;
      sh_d    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      q       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_state <= S_GRANT;
            r_win   <= w_win;
            gnt0    <= ~w_win;
            gnt1    <= w_win;
            sh_clr  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_GRANT: begin
          r_state <= S_SHIFT;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          sh_clr  <= 1'b0;
          sh_en   <= 1'b1;
          r_ptr   <= r_win;
          r_word  <= w_word;
          sh_d    <= w_word[WIDTH-1];
          r_sreg  <= w_word[WIDTH-2:0];
          r_cnt   <= '0;
        end
        S_SHIFT: begin
          if (r_cnt == c_LAST) begin
            r_state <= S_DONE;
            sh_en   <= 1'b0;
            sh_d    <= 1'b0;
            done    <= 1'b1;
            done_id <= r_win;
            q       <= r_word;
          end else begin
            r_cnt   <= r_cnt + c_CNT_W'(1);
            sh_d    <= r_sreg[WIDTH-2];
            r_sreg  <= r_sreg << 1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_arbiter.sv
// ============================================================================
//  Module   : tb_shift_reg_arbiter
//  Purpose  : Scoreboard bench for shift_reg_arbiter (WIDTH = 4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] data0, data1;
  logic         gnt0, gnt1, sh_clr, sh_en, sh_d, busy, done, done_id;
  logic [W-1:0] q;

  shift_reg_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .data0   (data0),
    .req1    (req1),
    .data1   (data1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sh_clr  (sh_clr),
    .sh_en   (sh_en),
    .sh_d    (sh_d),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .q       (q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [W-1:0] word;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic b2b   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [W-1:0] w);
    exp_t e;
    e.id   = id;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 30);
    chk(tag, 32'(gnt0 | gnt1), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy) && n < 60);
    chk(tag, sb.size(), 0);
  endtask

  // Monitor: sampled on the falling edge, compares against the scoreboard.
  int         cyc = 0;
  int         gnt_cyc = 0;
  int         last_gnt = -1;
  int         en_cnt = 0;
  logic       inflight = 1'b0;
  logic [W-1:0] bits = '0;

  always @(negedge clk) begin
    if (!rst) begin
      inflight = 1'b0;
      en_cnt   = 0;
      bits     = '0;
    end else begin
      cyc++;
      chk("excl_gnt", 32'(gnt0 & gnt1), 32'd0);
      chk("excl_sh", 32'(sh_en & sh_clr), 32'd0);
      chk("clr_with_gnt", 32'(sh_clr), 32'(gnt0 | gnt1));
      if (!b2b) last_gnt = -1;
      if (gnt0 || gnt1) begin
        if (sb.size() == 0) chk("gnt_unexp", 32'({gnt1, gnt0}), 32'd0);
        else chk("gnt_id", 32'(gnt1), 32'(sb[0].id));
        if (b2b && last_gnt >= 0) chk("period", cyc - last_gnt, W + 3);
        last_gnt = cyc;
        gnt_cyc  = cyc;
        en_cnt   = 0;
        bits     = '0;
        inflight = 1'b1;
      end
      chk("busy", 32'(busy), 32'(inflight));
      if (sh_en) begin
        bits = {bits[W-2:0], sh_d};
        en_cnt++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexp", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_id", 32'(done_id), 32'(e.id));
          chk("q", 32'(q), 32'(e.word));
          chk("serial", 32'(bits), 32'(e.word));
          chk("en_cycles", en_cnt, W);
          chk("latency", cyc - gnt_cyc, W + 1);
        end
        inflight = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({gnt0, gnt1, sh_clr, sh_en, sh_d, busy, done, done_id, q}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single transfer with explicit latency checks.
    data0 = 4'b1011; req0 = 1'b1; push(1'b0, 4'b1011);
    @(negedge clk);
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_gnt_pulse", 32'(gnt0), 32'd0);
    repeat (W) @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_q", 32'(q), 32'hB);
    @(negedge clk);
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_q_hold", 32'(q), 32'hB);

    // Tied requests from reset alternate 0,1,0.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    b2b = 1'b1;
    data0 = 4'h3; data1 = 4'hC;
    push(1'b0, 4'h3); push(1'b1, 4'hC); push(1'b0, 4'h3);
    req0 = 1'b1; req1 = 1'b1;
    for (int g = 0; g < 3; g++) wait_gnt("t2_gnt");
    req0 = 1'b0; req1 = 1'b0;
    drain("t2_drain");
    b2b = 1'b0;

    // A short req1 pulse while busy must never be granted.
    data0 = 4'hA; req0 = 1'b1; push(1'b0, 4'hA);
    wait_gnt("t3_gnt");
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    data1 = 4'h5; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    drain("t3_drain");
    repeat (10) @(negedge clk);
    chk("t3_idle", 32'(busy), 32'd0);

    // Reset during shift cycle 2 aborts the transfer.
    data0 = 4'h6; req0 = 1'b1; push(1'b0, 4'h6);
    wait_gnt("t4_gnt");
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t4_in_shift", 32'(sh_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("t4_rst_outs", 32'({gnt0, gnt1, sh_clr, sh_en, sh_d, busy, done, done_id, q}), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("t4_no_done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    data0 = 4'b1001; req0 = 1'b1; push(1'b0, 4'b1001);
    wait_gnt("t4_regnt");
    req0 = 1'b0;
    drain("t4_drain");

    // Single requesters with random words.
    for (int i = 0; i < 6; i++) begin
      logic         rid;
      logic [W-1:0] w;
      rid = 1'($urandom_range(0, 1));
      w   = W'($urandom);
      if (rid) begin data1 = w; req1 = 1'b1; end
      else     begin data0 = w; req0 = 1'b1; end
      push(rid, w);
      wait_gnt("t5_gnt");
      req0 = 1'b0; req1 = 1'b0;
      drain("t5_drain");
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_reg_arbiter.md
SHIFT_REG_ARBITER -- requirements
Module: shift_reg_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: word length shifted into the serial register per transfer (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req0  input  1  requester 0 transfer request, level.
REQ-005 SHALL have port data0  input  WIDTH  requester 0 parallel word.
REQ-006 SHALL have port req1  input  1  requester 1 transfer request, level.
REQ-007 SHALL have port data1  input  WIDTH  requester 1 parallel word.
REQ-008 SHALL have port gnt0  output  1  one-cycle grant/accept to requester 0.
REQ-009 SHALL have port gnt1  output  1  one-cycle grant/accept to requester 1.
REQ-010 SHALL have port sh_clr  output  1  clear strobe to the serial shift register.
REQ-011 SHALL have port sh_en  output  1  shift enable to the serial shift register.
REQ-012 SHALL have port sh_d  output  1  serial data bit to the shift register, MSB first.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a transfer has completed.
REQ-015 SHALL have port done_id  output  1  requester index of the completed transfer; valid while done=1.
REQ-016 SHALL have port q  output  WIDTH  word now held by the shift register; valid while done=1, holds until the next grant.

Function
REQ-017 SHALL implement a Moore FSM with states IDLE, GRANT, SHIFT, DONE; all outputs SHALL be registered or decoded from state only.
REQ-018 IDLE: req0/req1 sampled each edge; if any is high, next state GRANT; otherwise remain in IDLE.
REQ-019 Arbitration SHALL be round-robin: single request wins; on simultaneous req0 and req1, winner is the requester not granted last.
REQ-020 The last-grant pointer SHALL reset to 1, so requester 0 wins the first tie after reset.
REQ-021 GRANT (exactly 1 cycle): gnt of the winner = 1, sh_clr = 1; the winner's data latched at the closing edge; pointer updated; next state SHIFT.
REQ-022 The winner's req and data SHALL be required stable only until sampled in GRANT; a request dropped before GRANT is ignored without error.
REQ-023 SHIFT (exactly WIDTH cycles): sh_en = 1; sh_d = latched bit [WIDTH-1-k] in shift cycle k (k = 0..WIDTH-1); bit counter sized ceil(log2(WIDTH)) bits, no wrap past WIDTH-1; then DONE.
REQ-024 DONE (exactly 1 cycle): done = 1, done_id = winner, q = latched word; sh_en = 0; next state IDLE unconditionally.
REQ-025 Latency: req sampled at edge N -> gnt high in cycle N+1 -> done high in cycle N+WIDTH+2; back-to-back transfer period SHALL be WIDTH+3 cycles.
REQ-026 Requests arriving while busy SHALL not be granted until IDLE; requests are never lost while held.
REQ-027 gnt0 and gnt1 SHALL never be high together; sh_en and sh_clr SHALL never be high together.

Reset
REQ-028 On rst low, asynchronously: state IDLE, gnt0=gnt1=0, sh_clr=0, sh_en=0, sh_d=0, busy=0, done=0, done_id=0, q=0, counter=0, pointer=1.
REQ-029 Reset mid-transfer SHALL abort with no done pulse; operation resumes from IDLE on the first edge after rst returns high.

Verification
REQ-030 WIDTH=4, req0=1, data0=4'b1011 -> gnt0 pulse 1 cycle; sh_d = 1,0,1,1 with sh_en over 4 cycles; done=1, done_id=0, q=4'b1011 six cycles after req sampled.
REQ-031 req0=req1=1 held, data0=4'h3, data1=4'hC, from reset -> grants alternate 0,1,0 on a 7-cycle period; q = 3, C, 3 at the done pulses.
REQ-032 req1 pulsed 1 cycle while busy with requester 0 -> no gnt1; requester 0 transfer completes normally.
REQ-033 rst low during SHIFT cycle 2 -> all outputs 0 immediately, no done; after release, req0 sampled -> clean full transfer.
REQ-034 Any run: assertion checks gnt0&gnt1 never 1, sh_en&sh_clr never 1, busy==(state!=IDLE), exactly WIDTH sh_en cycles per grant.
